// File: rtl/bcd_field_cnt_pkg.sv
// Shared time-field definitions.
//   bcd_t            : one BCD digit
//   bcd_pair_t       : packed {tens, units} digit pair (8 bits)
//   bcd_pair_to_bin  : BCD pair -> binary (0..165 for any 4-bit digit pair)
//   bin_to_bcd_pair  : binary 0..99 -> BCD pair
//   SEC_MOD / MIN_MOD / HR_MOD : standard field moduli
package time_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd_pair_t;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;
    localparam int unsigned HR_MOD  = 24;

    // Digits are not range-checked here.
    // Worst case 15*10+15 = 165, so the result fits in 8 bits.
    function automatic logic [7:0] bcd_pair_to_bin(input bcd_pair_t p);
        return 8'(p.tens) * 8'd10 + 8'(p.units);
    endfunction

    function automatic bcd_pair_t bin_to_bcd_pair(input logic [7:0] v);
        bcd_pair_t p;
        p.tens  = 4'(v / 8'd10);
        p.units = 4'(v % 8'd10);
        return p;
    endfunction

endpackage

// File: rtl/bcd_field_cnt_if.sv
// Control/status bundle of one BCD time-field counter.
//   master : drives set, new_val, inc, dec; observes the field state
//   slave  : the counter itself
interface bcd_field_cnt_if;
    import time_pkg::*;

    logic      set;
    bcd_pair_t new_val;
    logic      inc;
    logic      dec;
    bcd_t      q_tens;
    bcd_t      q_units;
    logic      at_max;
    logic      at_zero;
    logic      carry;
    logic      borrow;
    logic      set_err;

    modport master (
        output set, new_val, inc, dec,
        input  q_tens, q_units, at_max, at_zero, carry, borrow, set_err
    );

    modport slave (
        input  set, new_val, inc, dec,
        output q_tens, q_units, at_max, at_zero, carry, borrow, set_err
    );

endinterface

// File: rtl/bcd_field_cnt_digit.sv
// One BCD digit register with load, step-up and step-down.
//   clk, resetn : clock, synchronous active-low reset (loads RST_VAL)
//   load, d     : load d this edge (highest priority after reset)
//   inc         : step up; wraps to 0 when q == wrap_val
//   dec         : step down; wraps to wrap_val when q == 0
//                 (only built with BCD_FIELD_DEC_EN)
//   wrap_val    : wrap point chosen by the parent for the current direction
//   q           : digit value
//   at_wrap     : q == wrap_val
module bcd_digit
    import time_pkg::*;
#(
    parameter bcd_t RST_VAL = 4'd0
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  bcd_t d,
    input  logic inc,
    input  logic dec,
    input  bcd_t wrap_val,
    output bcd_t q,
    output logic at_wrap
);

    bcd_t q_q;
    bcd_t q_d;

    assign at_wrap = (q_q == wrap_val);
    assign q       = q_q;

`ifdef BCD_FIELD_DEC_EN
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (inc) begin
            q_d = at_wrap ? 4'd0 : q_q + 4'd1;
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? wrap_val : q_q - 4'd1;
        end
    end
`else
    // Down-counting is not built; dec is deliberately left without a load.
    logic dec_unused;
    assign dec_unused = dec;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (inc) begin
            q_d = at_wrap ? 4'd0 : q_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_field_cnt.sv
// Two-digit BCD time-field counter (tens:units), range 0..MODULUS-1.
// Parameters:
//   MODULUS   : field modulus, 2..100 (60 for sec/min, 24 for hours)
//   RESET_VAL : binary value loaded on reset, < MODULUS
// Ports:
//   clk     : system clock
//   resetn  : synchronous active-low reset
//   bus     : bcd_field_cnt_if.slave
//     set/new_val : load a BCD pair (validated)
//     inc/dec     : step up/down one count
//     q_tens/q_units : current value
//     at_max/at_zero : value == MODULUS-1 / value == 0 (combinational)
//     carry/borrow   : wrap indicators for same-cycle cascading (combinational)
//     set_err        : registered pulse after a rejected set
// Build option:
//   BCD_FIELD_DEC_EN defined   : dec counts down and borrow is live.
//   BCD_FIELD_DEC_EN undefined : dec is ignored, borrow is 0.
//                                inc alone decides the step and the carry.
module bcd_field_cnt
    import time_pkg::*;
#(
    parameter int unsigned MODULUS   = 60,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic               clk,
    input  logic               resetn,
    bcd_field_cnt_if.slave     bus
);

    localparam bcd_pair_t MAX_PAIR  = bin_to_bcd_pair(8'(MODULUS - 1));
    localparam bcd_pair_t RST_PAIR  = bin_to_bcd_pair(8'(RESET_VAL));
    localparam bcd_t      DIGIT_MAX = 4'd9;

    logic set_ok;
    logic load;
    logic inc_step;
    logic dec_step;
    bcd_t tens_q;
    bcd_t units_q;
    logic tens_at_wrap;
    logic units_at_wrap;
    logic units_wrap_sel;
    bcd_t units_wrap;
    logic tens_inc;
    logic tens_dec;
    logic at_max;
    logic at_zero;
    logic set_err_q;
    logic set_err_d;

    // A set must carry two legal BCD digits and be inside the field range.
    assign set_ok = (bus.new_val.tens  <= DIGIT_MAX) &&
                    (bus.new_val.units <= DIGIT_MAX) &&
                    (bcd_pair_to_bin(bus.new_val) < 8'(MODULUS));
    assign load   = bus.set & set_ok;

`ifdef BCD_FIELD_DEC_EN
    // inc and dec together cancel out.
    assign inc_step = ~bus.set & bus.inc & ~bus.dec;
    assign dec_step = ~bus.set & bus.dec & ~bus.inc;
    // Counting up, units wrap early on the top tens value.
    // Counting down, units reload the short value when tens is 0 (00 -> MODULUS-1).
    assign units_wrap_sel = dec_step ? (tens_q == 4'd0) : tens_at_wrap;
    assign bus.carry  = resetn & ~bus.set & bus.inc & ~bus.dec & at_max;
    assign bus.borrow = resetn & ~bus.set & bus.dec & ~bus.inc & at_zero;
`else
    logic dec_unused;
    assign dec_unused     = bus.dec;
    assign inc_step       = ~bus.set & bus.inc;
    assign dec_step       = 1'b0;
    assign units_wrap_sel = tens_at_wrap;
    assign bus.carry      = resetn & ~bus.set & bus.inc & at_max;
    assign bus.borrow     = 1'b0;
`endif

    assign units_wrap = units_wrap_sel ? MAX_PAIR.units : DIGIT_MAX;
    assign tens_inc   = inc_step & units_at_wrap;
    assign tens_dec   = dec_step & (units_q == 4'd0);

    bcd_digit #(.RST_VAL(RST_PAIR.units)) u_units (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .d        (bus.new_val.units),
        .inc      (inc_step),
        .dec      (dec_step),
        .wrap_val (units_wrap),
        .q        (units_q),
        .at_wrap  (units_at_wrap)
    );

    bcd_digit #(.RST_VAL(RST_PAIR.tens)) u_tens (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .d        (bus.new_val.tens),
        .inc      (tens_inc),
        .dec      (tens_dec),
        .wrap_val (MAX_PAIR.tens),
        .q        (tens_q),
        .at_wrap  (tens_at_wrap)
    );

    assign at_max  = tens_at_wrap && (units_q == MAX_PAIR.units);
    assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);

    assign set_err_d = bus.set & ~set_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            set_err_q <= 1'b0;
        end else begin
            set_err_q <= set_err_d;
        end
    end

    assign bus.q_tens  = tens_q;
    assign bus.q_units = units_q;
    assign bus.at_max  = at_max;
    assign bus.at_zero = at_zero;
    assign bus.set_err = set_err_q;

endmodule

// File: tb/tb_bcd_field_cnt.sv
// Bench for bcd_field_cnt: one MODULUS=60/RESET_VAL=0 instance (index 0) and
// one MODULUS=24/RESET_VAL=12 instance (index 1), compared against an
// arithmetic model every cycle, plus directed literal checks.
module tb_bcd_field_cnt;

`ifdef BCD_FIELD_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_v [2];
    logic       set_v  [2];
    logic [7:0] nv_v   [2];
    logic       inc_v  [2];
    logic       dec_v  [2];

    logic [7:0] q_a      [2];
    logic       carry_a  [2];
    logic       borrow_a [2];
    logic       amax_a   [2];
    logic       azero_a  [2];
    logic       err_a    [2];

    bcd_field_cnt_if b60 ();
    bcd_field_cnt_if b24 ();

    assign b60.set     = set_v[0];
    assign b60.new_val = nv_v[0];
    assign b60.inc     = inc_v[0];
    assign b60.dec     = dec_v[0];
    assign b24.set     = set_v[1];
    assign b24.new_val = nv_v[1];
    assign b24.inc     = inc_v[1];
    assign b24.dec     = dec_v[1];

    assign q_a[0]      = {b60.q_tens, b60.q_units};
    assign carry_a[0]  = b60.carry;
    assign borrow_a[0] = b60.borrow;
    assign amax_a[0]   = b60.at_max;
    assign azero_a[0]  = b60.at_zero;
    assign err_a[0]    = b60.set_err;
    assign q_a[1]      = {b24.q_tens, b24.q_units};
    assign carry_a[1]  = b24.carry;
    assign borrow_a[1] = b24.borrow;
    assign amax_a[1]   = b24.at_max;
    assign azero_a[1]  = b24.at_zero;
    assign err_a[1]    = b24.set_err;

    bcd_field_cnt #(.MODULUS(60), .RESET_VAL(0)) dut60 (
        .clk    (clk),
        .resetn (rstn_v[0]),
        .bus    (b60)
    );

    bcd_field_cnt #(.MODULUS(24), .RESET_VAL(12)) dut24 (
        .clk    (clk),
        .resetn (rstn_v[1]),
        .bus    (b24)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int modv(input int k);
        return (k == 0) ? 60 : 24;
    endfunction

    function automatic int rstv(input int k);
        return (k == 0) ? 0 : 12;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic bit set_valid(input int k, input logic [7:0] nv);
        int t;
        int u;
        t = int'(nv[7:4]);
        u = int'(nv[3:0]);
        return (t <= 9) && (u <= 9) && (t * 10 + u < modv(k));
    endfunction

    int mv   [2];
    bit merr [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  m;
            bit  up;
            bit  dn;
            m  = modv(k);
            up = inc_v[k] && (!DEC_EN || !dec_v[k]);
            dn = DEC_EN && dec_v[k] && !inc_v[k];
            if (!rstn_v[k]) begin
                mv[k]   <= rstv(k);
                merr[k] <= 1'b0;
            end else if (set_v[k]) begin
                merr[k] <= !set_valid(k, nv_v[k]);
                if (set_valid(k, nv_v[k]))
                    mv[k] <= int'(nv_v[k][7:4]) * 10 + int'(nv_v[k][3:0]);
            end else begin
                merr[k] <= 1'b0;
                if (up)      mv[k] <= (mv[k] + 1) % m;
                else if (dn) mv[k] <= (mv[k] + m - 1) % m;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                int m;
                bit ec;
                bit eb;
                m  = modv(k);
                ec = rstn_v[k] && !set_v[k] && inc_v[k] && (!DEC_EN || !dec_v[k]) && (mv[k] == m - 1);
                eb = DEC_EN && rstn_v[k] && !set_v[k] && dec_v[k] && !inc_v[k] && (mv[k] == 0);
                chk8($sformatf("m%0d_q", m),       q_a[k],      to_bcd(mv[k]));
                chk1($sformatf("m%0d_carry", m),   carry_a[k],  ec);
                chk1($sformatf("m%0d_borrow", m),  borrow_a[k], eb);
                chk1($sformatf("m%0d_at_max", m),  amax_a[k],   mv[k] == m - 1);
                chk1($sformatf("m%0d_at_zero", m), azero_a[k],  mv[k] == 0);
                chk1($sformatf("m%0d_set_err", m), err_a[k],    merr[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input int k, input logic [7:0] nv);
        set_v[k] = 1'b1;
        nv_v[k]  = nv;
        tick();
        set_v[k] = 1'b0;
        $display("txn set m%0d new_val=%h -> q=%h set_err=%b", modv(k), nv, q_a[k], err_a[k]);
    endtask

    int ncarry;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn_v[k] = 1'b0;
            set_v[k]  = 1'b0;
            nv_v[k]   = 8'h00;
            inc_v[k]  = 1'b0;
            dec_v[k]  = 1'b0;
        end
        tick();
        check_en = 1'b1;
        tick();
        chk8("reset_q60", q_a[0], 8'h00);
        chk8("reset_q24", q_a[1], 8'h12);
        chk1("reset_err60", err_a[0], 1'b0);
        rstn_v[0] = 1'b1;
        rstn_v[1] = 1'b1;

        // 60 increments walk 00..59 then wrap, carry only at 59
        ncarry = 0;
        inc_v[0] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            chk8("walk_q", q_a[0], to_bcd(i));
            chk1("walk_carry", carry_a[0], i == 59);
            if (carry_a[0] === 1'b1) ncarry++;
            tick();
        end
        inc_v[0] = 1'b0;
        $display("txn walk m60 done q=%h carries=%0d", q_a[0], ncarry);
        chk8("walk_wrap_q", q_a[0], 8'h00);
        chk8("walk_ncarry", 8'(ncarry), 8'd1);

        // hours field: 23 -> 00 with carry, 24 rejected
        do_set(1, 8'h23);
        chk8("hr_set23", q_a[1], 8'h23);
        chk1("hr_at_max", amax_a[1], 1'b1);
        do_set(1, 8'h24);
        chk8("hr_set24_hold", q_a[1], 8'h23);
        chk1("hr_set24_err", err_a[1], 1'b1);
        tick();
        chk1("hr_err_clear", err_a[1], 1'b0);
        inc_v[1] = 1'b1;
        #1;
        chk1("hr_carry", carry_a[1], 1'b1);
        tick();
        inc_v[1] = 1'b0;
        chk8("hr_wrap", q_a[1], 8'h00);

        // bad units digit
        do_set(0, 8'h37);
        chk8("set37", q_a[0], 8'h37);
        do_set(0, 8'h5A);
        chk8("set5A_hold", q_a[0], 8'h37);
        chk1("set5A_err", err_a[0], 1'b1);
        tick();
        chk1("set5A_err_clear", err_a[0], 1'b0);

        // reset wins over inc at 37
        rstn_v[0] = 1'b0;
        inc_v[0]  = 1'b1;
        #1;
        chk1("rst_inc_carry", carry_a[0], 1'b0);
        tick();
        rstn_v[0] = 1'b1;
        inc_v[0]  = 1'b0;
        chk8("rst_inc_q", q_a[0], 8'h00);

        // set wins over inc at 59
        do_set(0, 8'h59);
        set_v[0] = 1'b1;
        nv_v[0]  = 8'h12;
        inc_v[0] = 1'b1;
        #1;
        chk1("set_inc_carry", carry_a[0], 1'b0);
        tick();
        set_v[0] = 1'b0;
        inc_v[0] = 1'b0;
        chk8("set_inc_q", q_a[0], 8'h12);

`ifdef BCD_FIELD_DEC_EN
        do_set(0, 8'h00);
        dec_v[0] = 1'b1;
        #1;
        chk1("dec_borrow", borrow_a[0], 1'b1);
        tick();
        dec_v[0] = 1'b0;
        chk8("dec_wrap", q_a[0], 8'h59);
        do_set(0, 8'h50);
        dec_v[0] = 1'b1;
        tick();
        chk8("dec_50", q_a[0], 8'h49);
        inc_v[0] = 1'b1;
        #1;
        chk1("incdec_carry", carry_a[0], 1'b0);
        chk1("incdec_borrow", borrow_a[0], 1'b0);
        tick();
        inc_v[0] = 1'b0;
        dec_v[0] = 1'b0;
        chk8("incdec_hold", q_a[0], 8'h49);
        do_set(1, 8'h00);
        dec_v[1] = 1'b1;
        tick();
        dec_v[1] = 1'b0;
        chk8("hr_dec_wrap", q_a[1], 8'h23);
`else
        do_set(0, 8'h00);
        dec_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("nodec_borrow", borrow_a[0], 1'b0);
            tick();
            chk8("nodec_q", q_a[0], 8'h00);
        end
        dec_v[0] = 1'b0;
`endif

        // randomized traffic on both fields
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                rstn_v[k] = ($urandom_range(0, 49) != 0);
                set_v[k]  = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) != 0)
                    nv_v[k] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                else
                    nv_v[k] = 8'($urandom);
                inc_v[k]  = 1'($urandom_range(0, 1));
                dec_v[k]  = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
